halut_decoder_mc: RTL and testbench



---
 rtl/halut_pkg.sv | 18 +
 rtl/halut_lut_bank.sv | 38 +++
 rtl/halut_decoder_mc.sv | 136 +++++++++++++
 tb/tb_halut_decoder_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halut_pkg.sv
// Shared types and width helpers for the multi-column HALUT decoder.
package halut_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      STALL = 2'd2
   } state_e;

   function automatic int acc_width(input int data_w, input int n_cb);
      return data_w + $clog2(n_cb);
   endfunction

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/halut_lut_bank.sv
// Flop-based LUT: one registered write port with column select and an
// M-wide combinational read port addressed by codebook and prototype.
module halut_lut_bank
   import halut_pkg::*;
#(
   parameter int C             = 32,
   parameter int K             = 16,
   parameter int M             = 4,
   parameter int DataTypeWidth = 8,
   parameter int TreeDepth     = $clog2(K),
   parameter int CAddrWidth    = $clog2(C),
   parameter int MAddrWidth    = addr_width(M)
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [CAddrWidth-1:0]      wc_i,
   input  logic [TreeDepth-1:0]       wk_i,
   input  logic [MAddrWidth-1:0]      wm_i,
   input  logic [DataTypeWidth-1:0]   wdata_i,
   input  logic [CAddrWidth-1:0]      rd_c_i,
   input  logic [TreeDepth-1:0]       rd_k_i,
   output logic [M*DataTypeWidth-1:0] rd_data_o
);

   logic [DataTypeWidth-1:0] mem_q [C][K][M];

   // Entry write; the table is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i && (int'(wc_i) < C) && (int'(wm_i) < M)) begin
         mem_q[wc_i][wk_i][wm_i] <= wdata_i;
      end
   end

   for (genvar m = 0; m < M; m++) begin : g_rd
      assign rd_data_o[m*DataTypeWidth +: DataTypeWidth] = mem_q[rd_c_i][rd_k_i][m];
   end

endmodule

// File: rtl/halut_decoder_mc.sv
// Multi-column HALUT decoder: accumulates C LUT lookups per row across M
// columns and hands the finished row out through a valid/ready port.
module halut_decoder_mc
   import halut_pkg::*;
#(
   parameter int K             = 16,
   parameter int C             = 32,
   parameter int M             = 4,
   parameter int DataTypeWidth = 8,
   parameter int AccWidth      = acc_width(DataTypeWidth, C),
   parameter int TreeDepth     = $clog2(K),
   parameter int CAddrWidth    = $clog2(C),
   parameter int MAddrWidth    = addr_width(M)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     we_i,
   input  logic [CAddrWidth-1:0]    wc_i,
   input  logic [TreeDepth-1:0]     wk_i,
   input  logic [MAddrWidth-1:0]    wm_i,
   input  logic [DataTypeWidth-1:0] wdata_i,
   input  logic                     clear_i,
   input  logic                     enc_valid_i,
   output logic                     enc_ready_o,
   input  logic [TreeDepth-1:0]     enc_k_i,
   output logic [CAddrWidth-1:0]    c_cnt_o,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [M*AccWidth-1:0]    res_data_o
);

   typedef logic signed [AccWidth-1:0] acc_t;
   localparam logic [CAddrWidth-1:0] CLast = CAddrWidth'(C - 1);

   logic [M*DataTypeWidth-1:0] lut_rd;
   acc_t                       lut_ext [M];
   state_e                     state_q, state_d;
   logic [CAddrWidth-1:0]      c_cnt_q, c_cnt_d;
   acc_t                       acc_q [M];
   acc_t                       acc_d [M];
   logic [M*AccWidth-1:0]      res_q, res_d;
   logic                       res_valid_q, res_valid_d;
   logic                       accept;
   logic                       last;

   halut_lut_bank #(
      .C             (C),
      .K             (K),
      .M             (M),
      .DataTypeWidth (DataTypeWidth)
   ) u_lut (
      .clk_i     (clk_i),
      .we_i      (we_i),
      .wc_i      (wc_i),
      .wk_i      (wk_i),
      .wm_i      (wm_i),
      .wdata_i   (wdata_i),
      .rd_c_i    (c_cnt_q),
      .rd_k_i    (enc_k_i),
      .rd_data_o (lut_rd)
   );

   for (genvar m = 0; m < M; m++) begin : g_ext
      assign lut_ext[m] = AccWidth'($signed(lut_rd[m*DataTypeWidth +: DataTypeWidth]));
   end

   // STALL means the last codebook is pending behind a held result, so only
   // a same-cycle downstream pop lets the final encoding in.
   assign enc_ready_o = !((state_q == STALL) && !res_ready_i);
   assign accept      = enc_valid_i & enc_ready_o;
   assign last        = (c_cnt_q == CLast);

   // Row accumulation, completion capture and output handshake.
   always_comb begin
      c_cnt_d     = c_cnt_q;
      acc_d       = acc_q;
      res_d       = res_q;
      res_valid_d = res_valid_q & ~res_ready_i;
      if (clear_i) begin
         c_cnt_d = '0;
         for (int m = 0; m < M; m++) begin
            acc_d[m] = '0;
         end
      end else if (accept && last) begin
         for (int m = 0; m < M; m++) begin
            res_d[m*AccWidth +: AccWidth] = acc_q[m] + lut_ext[m];
            acc_d[m] = '0;
         end
         c_cnt_d     = '0;
         res_valid_d = 1'b1;
      end else if (accept) begin
         for (int m = 0; m < M; m++) begin
            acc_d[m] = acc_q[m] + lut_ext[m];
         end
         c_cnt_d = c_cnt_q + CAddrWidth'(1);
      end else begin
         c_cnt_d = c_cnt_q;
      end
   end

   // Next FSM state derived from where the row will stand next cycle.
   always_comb begin
      state_d = ACCUM;
      if ((c_cnt_d == CLast) && res_valid_d) begin
         state_d = STALL;
      end else if (c_cnt_d == '0) begin
         state_d = IDLE;
      end else begin
         state_d = ACCUM;
      end
   end

   // State, counter, accumulator and result registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         c_cnt_q     <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         for (int m = 0; m < M; m++) begin
            acc_q[m] <= '0;
         end
      end else begin
         state_q     <= state_d;
         c_cnt_q     <= c_cnt_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         acc_q       <= acc_d;
      end
   end

   assign c_cnt_o     = c_cnt_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_q;

endmodule

// File: tb/tb_halut_decoder_mc.sv
// Randomized bench for halut_decoder_mc against a row-level reference model.
module tb_halut_decoder_mc;

   localparam int K  = 16;
   localparam int C  = 32;
   localparam int M  = 4;
   localparam int DW = 8;
   localparam int AW = DW + $clog2(C);
   localparam int TD = $clog2(K);
   localparam int CW = $clog2(C);
   localparam int MW = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            we_i;
   logic [CW-1:0]   wc_i;
   logic [TD-1:0]   wk_i;
   logic [MW-1:0]   wm_i;
   logic [DW-1:0]   wdata_i;
   logic            clear_i;
   logic            enc_valid_i;
   logic            enc_ready_o;
   logic [TD-1:0]   enc_k_i;
   logic [CW-1:0]   c_cnt_o;
   logic            res_valid_o;
   logic            res_ready_i;
   logic [M*AW-1:0] res_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   int lut [C][K][M];
   int m_cnt;
   int m_acc [M];
   int m_res [M];
   bit m_valid;

   halut_decoder_mc #(.K(K), .C(C), .M(M), .DataTypeWidth(DW)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .we_i        (we_i),
      .wc_i        (wc_i),
      .wk_i        (wk_i),
      .wm_i        (wm_i),
      .wdata_i     (wdata_i),
      .clear_i     (clear_i),
      .enc_valid_i (enc_valid_i),
      .enc_ready_o (enc_ready_o),
      .enc_k_i     (enc_k_i),
      .c_cnt_o     (c_cnt_o),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_data_o  (res_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] col_exp(input int v);
      return AW'(v);
   endfunction

   function automatic logic [AW-1:0] col_got(input int m);
      return res_data_o[m*AW +: AW];
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_valid = 1'b0;
      for (int m = 0; m < M; m++) begin
         m_acc[m] = 0;
         m_res[m] = 0;
      end
   endtask

   // Check this cycle against the model, then advance model and clock.
   task automatic step();
      bit rdy;
      bit acc;
      bit nvalid;
      #1;
      rdy = !(m_cnt == C - 1 && m_valid && !res_ready_i);
      check("enc_ready", 64'(enc_ready_o), 64'(rdy));
      check("c_cnt", 64'(c_cnt_o), 64'(m_cnt));
      check("res_valid", 64'(res_valid_o), 64'(m_valid));
      for (int m = 0; m < M; m++) begin
         check("res_col", 64'(col_got(m)), 64'(col_exp(m_res[m])));
      end
      acc    = enc_valid_i && rdy;
      nvalid = m_valid && !res_ready_i;
      if (clear_i) begin
         m_cnt = 0;
         for (int m = 0; m < M; m++) m_acc[m] = 0;
      end else if (acc) begin
         for (int m = 0; m < M; m++) m_acc[m] += lut[m_cnt][enc_k_i][m];
         if (m_cnt == C - 1) begin
            for (int m = 0; m < M; m++) begin
               m_res[m] = m_acc[m];
               m_acc[m] = 0;
            end
            m_cnt  = 0;
            nvalid = 1'b1;
         end else begin
            m_cnt++;
         end
      end
      m_valid = nvalid;
      if (we_i) lut[wc_i][wk_i][wm_i] = int'($signed(wdata_i));
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   function automatic int lut_val(input int mode, input int m);
      case (mode)
         0: return m + 1;
         1: return -128;
         2: return 127;
         3: return 1;
         default: return int'($urandom_range(0, 255)) - 128;
      endcase
   endfunction

   task automatic load_lut(input int mode);
      enc_valid_i = 1'b0;
      res_ready_i = 1'b1;
      clear_i     = 1'b0;
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k < K; k++) begin
            for (int m = 0; m < M; m++) begin
               we_i    = 1'b1;
               wc_i    = CW'(c);
               wk_i    = TD'(k);
               wm_i    = MW'(m);
               wdata_i = DW'(lut_val(mode, m));
               step();
            end
         end
      end
      we_i = 1'b0;
   endtask

   task automatic stream(input int n, input bit rr);
      for (int i = 0; i < n; i++) begin
         enc_valid_i = 1'b1;
         enc_k_i     = TD'($urandom_range(0, K - 1));
         res_ready_i = rr;
         step();
      end
      enc_valid_i = 1'b0;
   endtask

   task automatic check_row(input string tag, input int per_col [M]);
      check({tag, "_valid"}, 64'(res_valid_o), 64'(1));
      for (int m = 0; m < M; m++) begin
         check(tag, 64'(col_got(m)), 64'(col_exp(per_col[m])));
      end
   endtask

   initial begin
      int exp_row [M];
      int hs;
      rst_ni      = 1'b0;
      we_i        = 1'b0;
      wc_i        = '0;
      wk_i        = '0;
      wm_i        = '0;
      wdata_i     = '0;
      clear_i     = 1'b0;
      enc_valid_i = 1'b0;
      enc_k_i     = '0;
      res_ready_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      check("rst_c_cnt", 64'(c_cnt_o), 64'(0));
      check("rst_valid", 64'(res_valid_o), 64'(0));
      check("rst_data", 64'(res_data_o), 64'(0));
      check("rst_ready", 64'(enc_ready_o), 64'(1));
      rst_ni = 1'b1;
      step();

      // Column m holds m+1 everywhere.
      load_lut(0);
      stream(C, 1'b1);
      for (int m = 0; m < M; m++) exp_row[m] = C * (m + 1);
      check_row("row_m_plus_1", exp_row);
      check("row_c_cnt_wrap", 64'(c_cnt_o), 64'(0));
      step();

      // Extremes without wrap.
      load_lut(1);
      stream(C, 1'b1);
      for (int m = 0; m < M; m++) exp_row[m] = -4096;
      check_row("row_min", exp_row);
      load_lut(2);
      stream(C, 1'b1);
      for (int m = 0; m < M; m++) exp_row[m] = 4064;
      check_row("row_max", exp_row);

      // Backpressure: row 2 stalls only at its last codebook.
      stream(C, 1'b1);
      stream(C - 1, 1'b0);
      enc_valid_i = 1'b1;
      res_ready_i = 1'b0;
      #1;
      check("stall_ready", 64'(enc_ready_o), 64'(0));
      check("stall_c_cnt", 64'(c_cnt_o), 64'(C - 1));
      stream(3, 1'b0);
      stream(1, 1'b1);
      check("stall_release_valid", 64'(res_valid_o), 64'(1));
      res_ready_i = 1'b1;
      step();

      // Back-to-back rows, no bubbles.
      hs = 0;
      for (int i = 0; i < 3 * C + 1; i++) begin
         enc_valid_i = 1'b1;
         enc_k_i     = TD'($urandom_range(0, K - 1));
         res_ready_i = 1'b1;
         if (res_valid_o) hs++;
         step();
      end
      check("b2b_results", 64'(hs), 64'(3));
      enc_valid_i = 1'b0;

      // Clear mid-row with a held result.
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      stream(C, 1'b0);
      stream(10, 1'b0);
      clear_i     = 1'b1;
      enc_valid_i = 1'b1;
      res_ready_i = 1'b0;
      step();
      clear_i = 1'b0;
      check("clear_c_cnt", 64'(c_cnt_o), 64'(0));
      check("clear_held_valid", 64'(res_valid_o), 64'(1));
      stream(C - 1, 1'b0);
      stream(1, 1'b1);

      // Write/read collision on lut[5][3][2].
      load_lut(3);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < C; i++) begin
            enc_valid_i = 1'b1;
            res_ready_i = 1'b1;
            enc_k_i     = (i == 5) ? TD'(3) : TD'($urandom_range(0, K - 1));
            we_i        = (r == 0) && (i == 5);
            wc_i        = CW'(5);
            wk_i        = TD'(3);
            wm_i        = MW'(2);
            wdata_i     = DW'(7);
            step();
         end
         we_i = 1'b0;
         for (int m = 0; m < M; m++) exp_row[m] = (r == 1 && m == 2) ? C - 1 + 7 : C;
         check_row(r == 0 ? "collide_old" : "collide_new", exp_row);
      end
      enc_valid_i = 1'b0;

      // Randomized traffic with mid-row writes and clears.
      load_lut(4);
      for (int i = 0; i < 800; i++) begin
         enc_valid_i = ($urandom_range(0, 3) != 0);
         res_ready_i = ($urandom_range(0, 2) != 0);
         clear_i     = ($urandom_range(0, 60) == 0);
         enc_k_i     = TD'($urandom_range(0, K - 1));
         we_i        = ($urandom_range(0, 7) == 0);
         wc_i        = CW'($urandom_range(0, C - 1));
         wk_i        = TD'($urandom_range(0, K - 1));
         wm_i        = MW'($urandom_range(0, M - 1));
         wdata_i     = DW'($urandom_range(0, 255));
         step();
      end
      we_i    = 1'b0;
      clear_i = 1'b0;

      // Asynchronous reset mid-row with a held result.
      stream(C, 1'b0);
      stream(10, 1'b0);
      rst_ni = 1'b0;
      #2;
      check("arst_c_cnt", 64'(c_cnt_o), 64'(0));
      check("arst_valid", 64'(res_valid_o), 64'(0));
      check("arst_data", 64'(res_data_o), 64'(0));
      check("arst_ready", 64'(enc_ready_o), 64'(1));
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      stream(C, 1'b1);
      res_ready_i = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
